// File: rtl/mem_arbiter.sv
// mem_arbiter: three-port fixed-priority arbiter (video > DMA > CPU)
// sharing one memory command port, with CPU anti-starvation and timeout.
module mem_arbiter #(
  parameter int AW         = 25,
  parameter int DW         = 16,
  parameter int CPU_STARVE = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  output logic [1:0]    owner,
  output logic          err
);

  localparam int SW = $clog2(CPU_STARVE) + 1;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VID  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WAIT,
    S_ACK
  } state_t;

  state_t          r_state;
  logic [7:0]      r_cnt;
  logic [SW-1:0]   r_streak;
  logic [1:0]      r_owner;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [1:0]      r_mem_be;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_vid_ack;
  logic            r_dma_ack;
  logic            r_cpu_ack;
  logic            r_err;
  logic [DW-1:0]   r_vid_rdata;
  logic [DW-1:0]   r_dma_rdata;
  logic [DW-1:0]   r_cpu_rdata;

  logic            w_starve;
  logic            w_vid_win;
  logic            w_dma_win;
  logic            w_cpu_win;
  logic            w_any;
  logic [1:0]      w_owner;
  logic            w_we;
  logic [1:0]      w_be;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic [SW-1:0]   w_streak_nxt;
  logic            w_finish;
  logic [DW-1:0]   w_cap;

  assign w_any    = vid_req | dma_req | cpu_req;
  assign w_finish = mem_done | (r_cnt == 8'(TIMEOUT - 1));
  assign w_cap    = mem_done ? mem_rdata : '0;

  // Pick the winner and its command fields; CPU jumps DMA once starved.
  always_comb begin
    w_starve  = (r_streak == SW'(CPU_STARVE));
    w_vid_win = vid_req;
    w_cpu_win = !vid_req && cpu_req && (w_starve || !dma_req);
    w_dma_win = !vid_req && dma_req && !(w_starve && cpu_req);
    w_owner   = OWN_NONE;
    w_we      = 1'b0;
    w_be      = 2'b00;
    w_addr    = '0;
    w_wdata   = '0;
    unique case (1'b1)
      w_vid_win: begin
        w_owner = OWN_VID;
        w_be    = 2'b11;
        w_addr  = vid_addr;
      end
      w_dma_win: begin
        w_owner = OWN_DMA;
        w_we    = dma_we;
        w_be    = 2'b11;
        w_addr  = dma_addr;
        w_wdata = dma_wdata;
      end
      w_cpu_win: begin
        w_owner = OWN_CPU;
        w_we    = cpu_we;
        w_be    = cpu_be;
        w_addr  = cpu_addr;
        w_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  // Next starvation streak for the grant being made this cycle.
  always_comb begin
    w_streak_nxt = r_streak;
    if (w_cpu_win) begin
      w_streak_nxt = '0;
    end else if (w_dma_win) begin
      if (!cpu_req)
        w_streak_nxt = '0;
      else if (!w_starve)
        w_streak_nxt = r_streak + SW'(1);
    end
  end

  // Access sequencer: grant, one-cycle command, wait/timeout, ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_streak    <= '0;
      r_owner     <= OWN_NONE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_vid_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_err       <= 1'b0;
      r_vid_rdata <= '0;
      r_dma_rdata <= '0;
      r_cpu_rdata <= '0;
    end else begin
      r_mem_req <= 1'b0;
      r_vid_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_CMD;
            r_mem_req   <= 1'b1;
            r_owner     <= w_owner;
            r_mem_we    <= w_we;
            r_mem_be    <= w_be;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_streak    <= w_streak_nxt;
          end
        end
        S_CMD: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
        end
        S_WAIT: begin
          if (w_finish) begin
            r_state   <= S_ACK;
            r_err     <= !mem_done;
            r_vid_ack <= (r_owner == OWN_VID);
            r_dma_ack <= (r_owner == OWN_DMA);
            r_cpu_ack <= (r_owner == OWN_CPU);
            case (r_owner)
              OWN_VID: r_vid_rdata <= w_cap;
              OWN_DMA: r_dma_rdata <= w_cap;
              OWN_CPU: r_cpu_rdata <= w_cap;
              default: ;
            endcase
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_owner <= OWN_NONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vid_ack   = r_vid_ack;
  assign dma_ack   = r_dma_ack;
  assign cpu_ack   = r_cpu_ack;
  assign vid_rdata = r_vid_rdata;
  assign dma_rdata = r_dma_rdata;
  assign cpu_rdata = r_cpu_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign owner     = r_owner;
  assign err       = r_err;

endmodule
